// File: rtl/polar_sched_pkg.sv
// Shared types and helpers for the polar SC decode scheduler.
package polar_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        OP,
        DEC,
        FIN
    } state_t;

    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } op_t;

    // Beats needed to produce the 2^s outputs of stage s with 2^log2pe lanes.
    function automatic int unsigned beats_of(input int unsigned s, input int unsigned log2pe);
        if (s <= log2pe) begin
            return 1;
        end
        return 32'd1 << (s - log2pe);
    endfunction

endpackage

// File: rtl/polar_ctz.sv
// Combinational trailing-zero count; a zero input reports 0.
module polar_ctz #(
    parameter int W = 10
) (
    input  logic [W-1:0] value_i,
    output logic [W-1:0] count_o
);

    // Scanning from the MSB down leaves the lowest set bit's index last.
    always_comb begin
        count_o = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (value_i[k]) begin
                count_o = W'(k);
            end
        end
    end

endmodule

// File: rtl/polar_sc_schedule_ctrl.sv
// Successive-cancellation schedule controller: walks bits 0..N-1, issuing
// f/g beats per stage with LLR RAM addresses, then hands off each decision.
module polar_sc_schedule_ctrl #(
    parameter int CODE_LENGTH = 1024,
    parameter int LOG2_N      = 10,
    parameter int PE_NUM      = 64,
    parameter int LOG2_PE     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              op_is_g,
    output logic [LOG2_N-1:0] op_stage,
    output logic              op_src_chan,
    output logic [LOG2_N-1:0] op_rd_addr_a,
    output logic [LOG2_N-1:0] op_rd_addr_b,
    output logic [LOG2_N-1:0] op_wr_addr,
    output logic [LOG2_PE:0]  op_lanes_log2,
    output logic              dec_req,
    input  logic              dec_ack,
    output logic [LOG2_N-1:0] dec_idx
);

    import polar_sched_pkg::*;

    localparam int                LW         = LOG2_PE + 1;
    localparam logic [LOG2_N-1:0] ONE        = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] LAST_STAGE = LOG2_N'(LOG2_N - 1);
    localparam logic [LOG2_N-1:0] PE_STAGE   = LOG2_N'(LOG2_PE);
    localparam logic [LOG2_N-1:0] LAST_BIT   = LOG2_N'(CODE_LENGTH - 1);

    state_t            state_q;
    op_t               isG_q;
    logic [LOG2_N-1:0] bitIdx_q, beat_q, stage_q;
    logic [LOG2_N-1:0] addrA_q, addrB_q, wrAddr_q;
    logic [LW-1:0]     lanes_q;
    logic              busy_q, done_q, opValid_q, chan_q, decReq_q;

    logic [LOG2_N-1:0] ctzCount;
    logic [LOG2_N-1:0] stage_d, beat_d, pow2, base, j0;
    logic [LOG2_N-1:0] addrA_d, addrB_d, wrAddr_d;
    logic [LW-1:0]     lanes_d;
    op_t               isG_d;
    logic              chan_d, lastBeat, advance;

    polar_ctz #(.W(LOG2_N)) u_ctz (
        .value_i (bitIdx_q),
        .count_o (ctzCount)
    );

    // Next beat to present: the first beat of a bit in SETUP, else the successor
    // of the beat being accepted. The stage-0 underflow on the final beat is unused.
    always_comb begin
        lastBeat = (32'(beat_q) == beats_of(32'(stage_q), LOG2_PE) - 1);
        stage_d  = stage_q;
        beat_d   = beat_q + ONE;
        isG_d    = isG_q;
        if (state_q == SETUP) begin
            stage_d = (bitIdx_q == '0) ? LAST_STAGE : ctzCount;
            beat_d  = '0;
            isG_d   = (bitIdx_q == '0) ? OP_F : OP_G;
        end else if (lastBeat) begin
            stage_d = stage_q - ONE;
            beat_d  = '0;
            isG_d   = OP_F;
        end
        pow2     = ONE << stage_d;
        chan_d   = (stage_d == LAST_STAGE);
        base     = chan_d ? '0 : (pow2 << 1);
        j0       = LOG2_N'(32'(beat_d) * PE_NUM);
        addrA_d  = base + j0;
        addrB_d  = addrA_d + pow2;
        wrAddr_d = pow2 + j0;
        lanes_d  = (stage_d > PE_STAGE) ? LW'(LOG2_PE) : LW'(stage_d);
        advance  = (state_q == SETUP) ||
                   ((state_q == OP) && op_ready && !(lastBeat && (stage_q == '0)));
    end

    // Control FSM; every beat field is registered and only reloads on advance,
    // so the op bus is stable across stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            isG_q     <= OP_F;
            bitIdx_q  <= '0;
            beat_q    <= '0;
            stage_q   <= '0;
            addrA_q   <= '0;
            addrB_q   <= '0;
            wrAddr_q  <= '0;
            lanes_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            opValid_q <= 1'b0;
            chan_q    <= 1'b0;
            decReq_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SETUP;
                        busy_q   <= 1'b1;
                        bitIdx_q <= '0;
                    end
                end
                SETUP: begin
                    state_q   <= OP;
                    opValid_q <= 1'b1;
                end
                OP: begin
                    if (op_ready && lastBeat && (stage_q == '0)) begin
                        state_q   <= DEC;
                        opValid_q <= 1'b0;
                        decReq_q  <= 1'b1;
                    end
                end
                DEC: begin
                    if (dec_ack) begin
                        decReq_q <= 1'b0;
                        if (bitIdx_q == LAST_BIT) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= SETUP;
                            bitIdx_q <= bitIdx_q + ONE;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (advance) begin
                stage_q  <= stage_d;
                beat_q   <= beat_d;
                isG_q    <= isG_d;
                chan_q   <= chan_d;
                addrA_q  <= addrA_d;
                addrB_q  <= addrB_d;
                wrAddr_q <= wrAddr_d;
                lanes_q  <= lanes_d;
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign op_valid      = opValid_q;
    assign op_is_g       = isG_q;
    assign op_stage      = stage_q;
    assign op_src_chan   = chan_q;
    assign op_rd_addr_a  = addrA_q;
    assign op_rd_addr_b  = addrB_q;
    assign op_wr_addr    = wrAddr_q;
    assign op_lanes_log2 = lanes_q;
    assign dec_req       = decReq_q;
    assign dec_idx       = bitIdx_q;

endmodule

// File: tb/tb_polar_sc_schedule_ctrl.sv
// Scoreboard bench for the SC schedule controller: an N=8/PE=2 instance and an
// N=1024/PE=64 instance, one active at a time, checked against a loop model.
module tb_polar_sc_schedule_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, op_ready, dec_ack;
    logic taskStart0, taskStart1, noiseStart;
    logic start0, start1;
    int   sel;
    bit   stallEn, noiseEn;

    logic       s_busy, s_done, s_valid, s_isg, s_chan, s_req;
    logic [2:0] s_stage, s_a, s_b, s_w, s_idx;
    logic [1:0] s_lanes;
    logic       b_busy, b_done, b_valid, b_isg, b_chan, b_req;
    logic [9:0] b_stage, b_a, b_b, b_w, b_idx;
    logic [6:0] b_lanes;

    logic        mBusy, mDone, mValid, mReq, mIsG, mChan;
    logic [15:0] mStage, mLanes, mA, mB, mW, mIdx;

    int compareCount = 0;
    int failCount = 0;
    int beatCount, decCount, doneCount, beatIdx, expBeats, expDecs;
    logic [63:0] sbQ[$];
    logic [63:0] dirTab[5];
    logic prevReq = 1'b0;

    assign start0 = taskStart0 | (noiseStart & (sel == 0));
    assign start1 = taskStart1 | (noiseStart & (sel == 1));

    polar_sc_schedule_ctrl #(.CODE_LENGTH(8), .LOG2_N(3), .PE_NUM(2), .LOG2_PE(1)) u_small (
        .clk(clk), .reset(reset), .start(start0), .busy(s_busy), .done(s_done),
        .op_valid(s_valid), .op_ready(op_ready), .op_is_g(s_isg), .op_stage(s_stage),
        .op_src_chan(s_chan), .op_rd_addr_a(s_a), .op_rd_addr_b(s_b), .op_wr_addr(s_w),
        .op_lanes_log2(s_lanes), .dec_req(s_req), .dec_ack(dec_ack), .dec_idx(s_idx)
    );

    polar_sc_schedule_ctrl #(.CODE_LENGTH(1024), .LOG2_N(10), .PE_NUM(64), .LOG2_PE(6)) u_big (
        .clk(clk), .reset(reset), .start(start1), .busy(b_busy), .done(b_done),
        .op_valid(b_valid), .op_ready(op_ready), .op_is_g(b_isg), .op_stage(b_stage),
        .op_src_chan(b_chan), .op_rd_addr_a(b_a), .op_rd_addr_b(b_b), .op_wr_addr(b_w),
        .op_lanes_log2(b_lanes), .dec_req(b_req), .dec_ack(dec_ack), .dec_idx(b_idx)
    );

    always_comb begin
        if (sel == 0) begin
            {mBusy, mDone, mValid, mReq, mIsG, mChan} = {s_busy, s_done, s_valid, s_req, s_isg, s_chan};
            mStage = 16'(s_stage); mLanes = 16'(s_lanes);
            mA = 16'(s_a); mB = 16'(s_b); mW = 16'(s_w); mIdx = 16'(s_idx);
        end else begin
            {mBusy, mDone, mValid, mReq, mIsG, mChan} = {b_busy, b_done, b_valid, b_req, b_isg, b_chan};
            mStage = 16'(b_stage); mLanes = 16'(b_lanes);
            mA = 16'(b_a); mB = 16'(b_b); mW = 16'(b_w); mIdx = 16'(b_idx);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] packBeat(input logic g, input logic c, input logic [15:0] st,
                                             input logic [15:0] ln, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] w);
        return {12'h0, 3'b0, g, 3'b0, c, st[3:0], ln[3:0], a[11:0], b[11:0], w[11:0]};
    endfunction

    function automatic logic [63:0] decWord(input logic [15:0] idx);
        return {1'b1, 47'h0, idx};
    endfunction

    function automatic int ctzInt(input int v);
        int k = 0;
        while (k < 31 && !v[k]) k++;
        return k;
    endfunction

    // Reference SC walk: each bit descends from its start stage to stage 0.
    task automatic modelFrame(input int logN, input int logPe);
        expBeats = 0;
        expDecs  = 0;
        for (int i = 0; i < (1 << logN); i++) begin
            int  s;
            bit  g;
            if (i == 0) begin s = logN - 1; g = 1'b0; end
            else        begin s = ctzInt(i); g = 1'b1; end
            for (int st = s; st >= 0; st--) begin
                int nb   = (st <= logPe) ? 1 : (1 << (st - logPe));
                int base = (st == logN - 1) ? 0 : (1 << (st + 1));
                for (int b = 0; b < nb; b++) begin
                    int j0 = b * (1 << logPe);
                    sbQ.push_back(packBeat(g, st == logN - 1, 16'(st), 16'((st < logPe) ? st : logPe),
                                           16'(base + j0), 16'(base + j0 + (1 << st)), 16'((1 << st) + j0)));
                    expBeats++;
                end
                g = 1'b0;
            end
            sbQ.push_back(decWord(16'(i)));
            expDecs++;
        end
    endtask

    // Monitor: samples on the falling edge and pops the scoreboard on handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mValid) begin
                    logic [63:0] obs;
                    obs = packBeat(mIsG, mChan, mStage, mLanes, mA, mB, mW);
                    checkOutput("sb_has_beat", 128'(sbQ.size() != 0), 128'(1));
                    if (sbQ.size() != 0) checkOutput("beat", 128'(obs), 128'(sbQ[0]));
                    if (op_ready) begin
                        if (sel == 0 && beatIdx < 5) checkOutput("directed_beat", 128'(obs), 128'(dirTab[beatIdx]));
                        if (sbQ.size() != 0) void'(sbQ.pop_front());
                        beatCount++;
                        beatIdx++;
                    end
                end
                if (mReq && !prevReq) begin
                    checkOutput("sb_has_dec", 128'(sbQ.size() != 0), 128'(1));
                    if (sbQ.size() != 0) begin
                        checkOutput("dec_idx", 128'(decWord(mIdx)), 128'(sbQ[0]));
                        void'(sbQ.pop_front());
                    end
                    decCount++;
                end
                if (mDone) doneCount++;
            end
            prevReq = mReq;
        end
    end

    // Responders: random stalls, one-cycle-late acks, and optional spurious start/ack noise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            op_ready = stallEn ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mReq && !dec_ack)           dec_ack = 1'b1;
            else if (noiseEn && mValid)     dec_ack = 1'($urandom_range(0, 1));
            else                            dec_ack = 1'b0;
            noiseStart = (noiseEn && mBusy) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic checkResetOutputs(input string tag);
        logic [101:0] allOut;
        allOut = {mBusy, mDone, mValid, mReq, mIsG, mChan, mStage, mLanes, mA, mB, mW, mIdx};
        checkOutput(tag, 128'(allOut), 128'(0));
    endtask

    task automatic startFrame(input int which);
        int cyc = 0;
        bit seen = 1'b0;
        sel = which;
        beatCount = 0; decCount = 0; doneCount = 0; beatIdx = 0;
        sbQ.delete();
        if (which == 0) modelFrame(3, 1);
        else            modelFrame(10, 6);
        @(posedge clk); #1;
        if (which == 0) taskStart0 = 1'b1; else taskStart1 = 1'b1;
        @(posedge clk); #1;
        taskStart0 = 1'b0;
        taskStart1 = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mValid) seen = 1'b1;
        end
        checkOutput("first_op_latency", 128'(cyc), 128'(2));
    endtask

    task automatic waitDone();
        int cyc = 0;
        while (doneCount == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checkOutput("done_pulses", 128'(doneCount), 128'(1));
        checkOutput("busy_after_done", 128'(mBusy), 128'(0));
        checkOutput("done_width", 128'(mDone), 128'(0));
        checkOutput("beat_count", 128'(beatCount), 128'(expBeats));
        checkOutput("dec_count", 128'(decCount), 128'(expDecs));
        checkOutput("sb_drained", 128'(sbQ.size()), 128'(0));
        if (sel == 0) begin
            checkOutput("beat_count_n8", 128'(beatCount), 128'(16));
            checkOutput("dec_count_n8", 128'(decCount), 128'(8));
        end
    endtask

    task automatic applyStimulus(input int which, input bit stall, input bit noise);
        stallEn = stall;
        noiseEn = noise;
        startFrame(which);
        waitDone();
        stallEn = 1'b0;
        noiseEn = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  found;
        reset = 1'b1; op_ready = 1'b1; dec_ack = 1'b0; noiseStart = 1'b0;
        taskStart0 = 1'b0; taskStart1 = 1'b0; stallEn = 1'b0; noiseEn = 1'b0; sel = 0;
        dirTab[0] = packBeat(1'b0, 1'b1, 16'd2, 16'd1, 16'd0, 16'd4, 16'd4);
        dirTab[1] = packBeat(1'b0, 1'b1, 16'd2, 16'd1, 16'd2, 16'd6, 16'd6);
        dirTab[2] = packBeat(1'b0, 1'b0, 16'd1, 16'd1, 16'd4, 16'd6, 16'd2);
        dirTab[3] = packBeat(1'b0, 1'b0, 16'd0, 16'd0, 16'd2, 16'd3, 16'd1);
        dirTab[4] = packBeat(1'b1, 1'b0, 16'd0, 16'd0, 16'd2, 16'd3, 16'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset_small");
        sel = 1;
        #1;
        checkResetOutputs("reset_big");
        sel = 0;
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b1);

        startFrame(0);
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (mValid && mIdx == 16'd3) found = 1'b1;
        end
        checkOutput("reached_bit3_op", 128'(found), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset_mid_frame");
        sbQ.delete();
        applyStimulus(0, 1'b0, 1'b0);

        applyStimulus(1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/polar_sc_schedule_ctrl.md
Name: polar_sc_schedule_ctrl

Overview:
- Sequences one successive-cancellation (SC) decode of a CODE_LENGTH polar frame over a shared f/g LLR datapath.
- Walks bit indices 0..N-1. For each bit it issues f/g operation beats, with RAM addresses, stage by stage.
- After the stage-0 beat it hands off to the bit-decision / partial-sum unit and waits for an acknowledge.
- Sits between the top-level decoder FSM (start/done), the LLR RAMs + PE array (op bus), and the decision unit (dec handshake).

Parameters:
- CODE_LENGTH, 1024, N; power of 2, >= 4.
- LOG2_N, 10, log2(CODE_LENGTH); number of stages n.
- PE_NUM, 64, parallel f/g lanes; power of 2, 1 <= PE_NUM <= N/2.
- LOG2_PE, 6, log2(PE_NUM).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last decision is acknowledged
- op_valid  out  1  op beat present
- op_ready  in  1  datapath accepts beat (stall when low)
- op_is_g  out  1  0 = f, 1 = g
- op_stage  out  LOG2_N  stage s of beat; output vector length 2^s
- op_src_chan  out  1  1 = read channel LLR RAM (s = n-1), 0 = mid RAM
- op_rd_addr_a  out  LOG2_N  element index of lane 0, upper operand
- op_rd_addr_b  out  LOG2_N  element index of lane 0, lower operand (a + 2^s)
- op_wr_addr  out  LOG2_N  mid-RAM element index of lane 0 result
- op_lanes_log2  out  LOG2_PE+1  log2 of active lanes = min(s, LOG2_PE)
- dec_req  out  1  request decision of bit dec_idx (level)
- dec_ack  in  1  decision + partial-sum update complete
- dec_idx  out  LOG2_N  current bit index; also frozen-indication RAM read address

Behaviour:
- Reset values: all outputs 0 (busy, done, op_valid, dec_req, addresses, fields); state IDLE, bit counter 0. Reset mid-frame aborts immediately with no done pulse.
- States: IDLE, SETUP, OP, DEC, FIN.
- IDLE:
  - start=1 -> SETUP, busy=1 next cycle, bit index i=0.
  - start while busy is ignored.
- SETUP (1 cycle):
  - i=0: s=n-1, op=f.
  - i>0: t=ctz(i), s=t, op=g.
  - Beat counter b=0. Go to OP.
- OP:
  - op_valid=1.
  - Beats per stage B(s) = max(1, 2^s / PE_NUM); j0 = b*PE_NUM.
  - Addresses:
    - s=n-1: src base 0, op_src_chan=1.
    - Otherwise: src base 2^(s+1), op_src_chan=0.
    - rd_addr_a = base+j0; rd_addr_b = base+j0+2^s; wr_addr = 2^s+j0.
  - Beat advances only on op_valid & op_ready. Outputs hold stable while stalled.
  - On last beat of stage s:
    - s>0: s<=s-1, op<=f, b<=0.
    - s=0: -> DEC.
- DEC:
  - dec_req=1, op_valid=0.
  - dec_ack:
    - i=N-1: -> FIN.
    - Otherwise: i<=i+1 -> SETUP.
  - dec_ack is ignored outside DEC.
- FIN: done=1 for one cycle, busy=0 -> IDLE. A new start is accepted the cycle after FIN.
- Latency: first op_valid 2 cycles after start accepted. Per bit, with no stalls: 1 setup + sum of beats + decision wait.
- All address arithmetic is modulo 2^LOG2_N. Maximum value N-1 is never exceeded by construction.
- ctz computed on LOG2_N-bit i; i=0 is never fed to ctz.

Decomposition:
- Package polar_sched_pkg:
  - state enum (IDLE/SETUP/OP/DEC/FIN).
  - op enum (OP_F=0, OP_G=1).
  - Function beats_of(s).
- Sub-module polar_ctz: combinational trailing-zero count, LOG2_N in -> LOG2_N out. It is shared later by the partial-sum unit.

Test Plan:
- N=8, PE_NUM=2, op_ready=1, dec_ack 1 cycle after dec_req:
  - bit 0 beats = f s2 (a=0,b=4,w=4), f s2 (a=2,b=6,w=6), f s1 (a=4,b=6,w=2), f s0 (a=2,b=3,w=1).
  - Then dec_req with dec_idx=0.
- Same config, full frame:
  - exactly 16 op beats and 8 dec_req.
  - bit 4 starts g s2 with op_src_chan=1.
  - bit 1 is single g s0 (a=2,b=3,w=1).
  - one done pulse; busy low after.
- Random op_ready stalls (~50%): beat sequence and addresses identical to no-stall run; held fields never change while op_valid & !op_ready.
- N=1024, PE_NUM=64: bit 0 stage 9 takes 8 beats, stage 5 takes 1 beat with op_lanes_log2=5; bit 512 begins g s9.
- Reset asserted during OP of bit 3: next cycle all outputs 0, state IDLE; fresh start decodes from bit 0.
- start pulsed during busy and dec_ack pulsed in OP: no effect on sequence or counts.
